mxv_cluster_arbiter: RTL
========================

Name: mxv_cluster_arbiter

Overview:
- Shares one matrix_by_vector_v3_with_control engine between several cluster requesters.
- Arbitrates round-robin and latches the winner's mat/vector operands.
- Sequences the engine's level-sensitive start / finish handshake, with a mandatory start-low gap between jobs.
- Returns a one-cycle completion pulse to the winner, and aborts hung jobs via a watchdog.

Parameters:
- no_of_requesters, 4, number of cluster requesters (2..8)
- element_width, 32, bits per matrix/vector element
- no_of_eqn_per_cluster, 10, equations per cluster
- no_of_elements_of_mat, 3*(no_of_eqn_per_cluster-1)+1, tridiagonal element count
- timeout_cycles, 255, maximum RUN cycles before abort (1..65535)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req  in  no_of_requesters  per-requester job request, level
- req_mat  in  no_of_requesters*element_width*no_of_elements_of_mat  packed mats; requester k at slice k (k=0 LSBs)
- req_vector  in  no_of_requesters*element_width*no_of_eqn_per_cluster  packed vectors; same packing
- grant  out  no_of_requesters  one-hot owner, held from LOAD through DONE
- done  out  no_of_requesters  one-cycle one-hot completion pulse
- busy  out  1  high in every state except IDLE
- engine_start  out  1  drives engine start
- engine_mat  out  element_width*no_of_elements_of_mat  latched mat
- engine_vector  out  element_width*no_of_eqn_per_cluster  latched vector
- engine_finish  in  1  engine finish, level
- timeout_err  out  1  one-cycle pulse on watchdog abort
- err_id  out  3  index of the aborted requester; holds until next abort

Behaviour:
- Reset values: grant=0, done=0, busy=0, engine_start=0, engine_mat=0, engine_vector=0, timeout_err=0, err_id=0, rr_ptr=0, state=IDLE. Reset mid-job aborts immediately; no done pulse.
- IDLE:
  - If req!=0, pick the first set bit scanning upward from rr_ptr with wrap-around.
  - Register the winner index and go to LOAD.
  - If req==0, stay in IDLE.
- LOAD (1 cycle):
  - Capture the winner's req_mat and req_vector slices into engine_mat and engine_vector.
  - Assert grant[winner]. Go to RUN.
- RUN:
  - engine_start=1; watchdog counts from 0.
  - On engine_finish=1, go to DONE.
  - If the watchdog reaches timeout_cycles first, go to ABORT.
  - Operands are frozen for the whole run; req changes are ignored, including the winner dropping req.
- DONE (1 cycle):
  - engine_start=0; done[winner]=1; rr_ptr = winner+1, wrapping at no_of_requesters.
  - Go to GAP.
- ABORT (1 cycle):
  - engine_start=0; timeout_err=1; err_id=winner.
  - rr_ptr advances exactly as in DONE. Go to GAP.
- GAP:
  - engine_start=0 and grant=0.
  - Stay until engine_finish=0, and for at least 1 cycle, so the engine clears its counters. Then go to IDLE.
- Latency, uncontended job: req high at cycle 0 → LOAD at 1 → engine_start high at 2 → done one cycle after engine_finish is sampled high.
- Back-to-back:
  - A requester still holding req when GAP ends is eligible again.
  - Round-robin order guarantees every other pending requester is served first.
- Simultaneous events:
  - engine_finish and the watchdog expiring on the same cycle: finish wins (DONE, no error).
  - A new req arriving while busy waits for IDLE; it is never dropped.
- The winner index is held in a register; grant is decoded from it, so grant is always one-hot or zero.

Optional Feature:
- Macro: MXV_ARB_FIXED_PRIORITY_EN.
- Defined:
  - Arbitration is fixed priority; the lowest-index active req wins.
  - rr_ptr is not implemented; requester 0 can starve the others.
- Undefined: round-robin exactly as specified above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then req=4'b0010 with requester 1 mat=all 32'h3F800000 → engine_mat matches at RUN entry. Engine model asserts finish 7 cycles after start → done=4'b0010 for exactly 1 cycle, busy low after GAP.
- req=4'b1111 held, finish after 7 cycles each → grant order 0,1,2,3,0. Each engine_start rising edge is preceded by ≥1 low cycle.
- Engine model never asserts finish, timeout_cycles=20 → ABORT on RUN cycle 20, timeout_err pulse, err_id=2 for requester 2, no done, arbiter returns to IDLE.
- finish coincident with watchdog expiry at cycle 20 → done pulses, timeout_err stays 0.
- Reset asserted mid-RUN → all outputs at reset values next cycle, rr_ptr=0.
- With MXV_ARB_FIXED_PRIORITY_EN, req=4'b1001 held → requester 0 granted every job, requester 3 never granted.

Source files
------------

// File: rtl/mxv_cluster_arbiter_if.sv
// Requester/engine bundle of the matrix-by-vector cluster arbiter.
// The master modport is the requester/engine side; the slave modport is the arbiter.
interface mxv_cluster_arbiter_if #(
  parameter int unsigned no_of_requesters      = 4,
  parameter int unsigned element_width         = 32,
  parameter int unsigned no_of_eqn_per_cluster = 10,
  parameter int unsigned no_of_elements_of_mat = 3*(no_of_eqn_per_cluster-1)+1
);
  localparam int unsigned mat_w = element_width*no_of_elements_of_mat;
  localparam int unsigned vec_w = element_width*no_of_eqn_per_cluster;

  logic [no_of_requesters-1:0]       req;
  logic [no_of_requesters*mat_w-1:0] req_mat;
  logic [no_of_requesters*vec_w-1:0] req_vector;
  logic [no_of_requesters-1:0]       grant;
  logic [no_of_requesters-1:0]       done;
  logic                              busy;
  logic                              engine_start;
  logic [mat_w-1:0]                  engine_mat;
  logic [vec_w-1:0]                  engine_vector;
  logic                              engine_finish;
  logic                              timeout_err;
  logic [2:0]                        err_id;

  modport master (
    output req, req_mat, req_vector, engine_finish,
    input  grant, done, busy, engine_start, engine_mat, engine_vector, timeout_err, err_id
  );

  modport slave (
    input  req, req_mat, req_vector, engine_finish,
    output grant, done, busy, engine_start, engine_mat, engine_vector, timeout_err, err_id
  );
endinterface

// File: rtl/mxv_cluster_arbiter.sv
// Shares one matrix_by_vector engine among cluster requesters with a start/finish handshake and watchdog.
// Define MXV_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module mxv_cluster_arbiter #(
  parameter int unsigned no_of_requesters      = 4,
  parameter int unsigned element_width         = 32,
  parameter int unsigned no_of_eqn_per_cluster = 10,
  parameter int unsigned no_of_elements_of_mat = 3*(no_of_eqn_per_cluster-1)+1,
  parameter int unsigned timeout_cycles        = 255
) (
  input logic                  clk,
  input logic                  reset,
  mxv_cluster_arbiter_if.slave bus
);
  localparam int unsigned mat_w = element_width*no_of_elements_of_mat;
  localparam int unsigned vec_w = element_width*no_of_eqn_per_cluster;
  localparam int unsigned idx_w = (no_of_requesters > 1) ? $clog2(no_of_requesters) : 1;
  localparam int unsigned wd_w  = 16;
  localparam logic [wd_w-1:0]  wd_last  = wd_w'(timeout_cycles - 1);
  localparam logic [idx_w-1:0] last_idx = idx_w'(no_of_requesters - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ABORT, GAP} state_t;

  state_t                      state, state_n;
  logic [idx_w-1:0]            winner, winner_n, pick;
  logic                        found;
  logic [wd_w-1:0]             wd_cnt, wd_cnt_n;
  logic [no_of_requesters-1:0] grant_q, grant_n, done_q, done_n;
  logic                        busy_q, busy_n, start_q, start_n, terr_q, terr_n;
  logic [2:0]                  err_id_q, err_id_n;
  logic [mat_w-1:0]            mat_q, mat_n;
  logic [vec_w-1:0]            vec_q, vec_n;
  logic [mat_w-1:0]            mat_slice [no_of_requesters];
  logic [vec_w-1:0]            vec_slice [no_of_requesters];

  // Per-requester operand views of the packed request buses
  for (genvar g = 0; g < no_of_requesters; g++) begin : g_slice
    assign mat_slice[g] = bus.req_mat[g*mat_w +: mat_w];
    assign vec_slice[g] = bus.req_vector[g*vec_w +: vec_w];
  end

`ifdef MXV_ARB_FIXED_PRIORITY_EN
  // Lowest active index wins
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < no_of_requesters; i++) begin
      if (!found && bus.req[idx_w'(i)]) begin
        found = 1'b1;
        pick  = idx_w'(i);
      end
    end
  end
`else
  logic [idx_w-1:0] rr_ptr, rr_ptr_n, nxt_ptr;

  assign nxt_ptr = (winner == last_idx) ? '0 : winner + idx_w'(1);

  // First active request at or after rr_ptr, wrapping around
  always_comb begin
    int unsigned k;
    found = 1'b0;
    pick  = '0;
    k     = 0;
    for (int unsigned i = 0; i < no_of_requesters; i++) begin
      k = 32'(rr_ptr) + i;
      if (k >= no_of_requesters) k = k - no_of_requesters;
      if (!found && bus.req[idx_w'(k)]) begin
        found = 1'b1;
        pick  = idx_w'(k);
      end
    end
  end
`endif

  // Next state and next values of every registered output
  always_comb begin
    state_n  = state;
    winner_n = winner;
    wd_cnt_n = wd_cnt;
    err_id_n = err_id_q;
    mat_n    = mat_q;
    vec_n    = vec_q;
`ifndef MXV_ARB_FIXED_PRIORITY_EN
    rr_ptr_n = rr_ptr;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          winner_n = pick;
          state_n  = LOAD;
        end
      end
      LOAD: begin
        mat_n    = mat_slice[winner];
        vec_n    = vec_slice[winner];
        wd_cnt_n = '0;
        state_n  = RUN;
      end
      RUN: begin
        // finish beats a watchdog expiring on the same cycle
        if (bus.engine_finish) begin
          state_n = DONE;
`ifndef MXV_ARB_FIXED_PRIORITY_EN
          rr_ptr_n = nxt_ptr;
`endif
        end else if (wd_cnt >= wd_last) begin
          state_n  = ABORT;
          err_id_n = 3'(winner);
`ifndef MXV_ARB_FIXED_PRIORITY_EN
          rr_ptr_n = nxt_ptr;
`endif
        end else begin
          wd_cnt_n = wd_cnt + wd_w'(1);
        end
      end
      DONE:    state_n = GAP;
      ABORT:   state_n = GAP;
      GAP:     if (!bus.engine_finish) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n  = (state_n != IDLE);
    start_n = (state_n == RUN);
    terr_n  = (state_n == ABORT);
    grant_n = '0;
    done_n  = '0;
    if (state_n inside {LOAD, RUN, DONE, ABORT}) grant_n[winner_n] = 1'b1;
    if (state_n == DONE) done_n[winner_n] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      winner   <= '0;
      wd_cnt   <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      terr_q   <= 1'b0;
      err_id_q <= '0;
      mat_q    <= '0;
      vec_q    <= '0;
`ifndef MXV_ARB_FIXED_PRIORITY_EN
      rr_ptr   <= '0;
`endif
    end else begin
      state    <= state_n;
      winner   <= winner_n;
      wd_cnt   <= wd_cnt_n;
      grant_q  <= grant_n;
      done_q   <= done_n;
      busy_q   <= busy_n;
      start_q  <= start_n;
      terr_q   <= terr_n;
      err_id_q <= err_id_n;
      mat_q    <= mat_n;
      vec_q    <= vec_n;
`ifndef MXV_ARB_FIXED_PRIORITY_EN
      rr_ptr   <= rr_ptr_n;
`endif
    end
  end

  assign bus.grant         = grant_q;
  assign bus.done          = done_q;
  assign bus.busy          = busy_q;
  assign bus.engine_start  = start_q;
  assign bus.engine_mat    = mat_q;
  assign bus.engine_vector = vec_q;
  assign bus.timeout_err   = terr_q;
  assign bus.err_id        = err_id_q;
endmodule
